// File: rtl/sevseg_reader_pkg.sv
// Shared types and constants for the 7-segment scan reader.
// Contents: glyph patterns (segments a..g in bits 0..6, active-high),
// code_t, digit_t, and the sampling FSM state type.
// Macro SEVSEG_DP_CAPTURE_EN adds a dp field to digit_t.
package sevseg_reader_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_7_ALT = 7'h27;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_9_ALT = 7'h67;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B6    = 7'h7C;  // b, or a 6 without its top segment
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef logic [3:0] code_t;

  typedef struct packed {
    code_t code;
    logic  blank;
    logic  err;
`ifdef SEVSEG_DP_CAPTURE_EN
    logic  dp;
`endif
  } digit_t;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/sevseg_glyph_encoder.sv
// Combinational glyph-to-code encoder.
// Ports: seg (active-high segments a..g), hex_en (0x7C -> B when set, else 6),
//        glyph (code/blank/err; dp field, if built with SEVSEG_DP_CAPTURE_EN, is 0).
module sevseg_glyph_encoder
  import sevseg_reader_pkg::*;
(
  input  logic [6:0] seg,
  input  logic       hex_en,
  output digit_t     glyph
);

  always_comb begin
    glyph = '0;
    case (seg)
      GLYPH_0:                  glyph.code = 4'h0;
      GLYPH_1:                  glyph.code = 4'h1;
      GLYPH_2:                  glyph.code = 4'h2;
      GLYPH_3:                  glyph.code = 4'h3;
      GLYPH_4:                  glyph.code = 4'h4;
      GLYPH_5:                  glyph.code = 4'h5;
      GLYPH_6:                  glyph.code = 4'h6;
      GLYPH_7, GLYPH_7_ALT:     glyph.code = 4'h7;
      GLYPH_8:                  glyph.code = 4'h8;
      GLYPH_9, GLYPH_9_ALT:     glyph.code = 4'h9;
      GLYPH_A:                  glyph.code = 4'hA;
      GLYPH_B6:                 glyph.code = hex_en ? 4'hB : 4'h6;
      GLYPH_C:                  glyph.code = 4'hC;
      GLYPH_D:                  glyph.code = 4'hD;
      GLYPH_E:                  glyph.code = 4'hE;
      GLYPH_F:                  glyph.code = 4'hF;
      GLYPH_BLANK:              glyph.blank = 1'b1;
      default:                  glyph.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_reader.sv
// Multiplexed 7-segment bus reader: samples each strobed digit once it has
// settled, debounces per digit, and offers full frames on valid/ready.
// Ports: clk, rst (async, active high), seg_in, dig_in, al (active-low segs),
//        hex_en, frame_data/blank/err/ovr/valid out, frame_ready in.
// Macro SEVSEG_DP_CAPTURE_EN adds dp_in and frame_dp.
module sevseg_scan_reader
  import sevseg_reader_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned STABLE_SCANS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_in,
  input  logic                    al,
  input  logic                    hex_en,
`ifdef SEVSEG_DP_CAPTURE_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   frame_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_ovr,
  output logic                    frame_valid,
  input  logic                    frame_ready
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SCNT_W = $clog2(STABLE_SCANS + 1);
  localparam logic [CNT_W-1:0]  SETTLE_L = CNT_W'(SETTLE_CYCLES);
  localparam logic [SCNT_W-1:0] STABLE_L = SCNT_W'(STABLE_SCANS);

  logic [6:0]            seg_m, seg_s;
  logic [NUM_DIGITS-1:0] dig_m, dig_s;
  logic                  al_m, al_s;
`ifdef SEVSEG_DP_CAPTURE_EN
  logic                  dp_m, dp_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m <= '0; seg_s <= '0;
      dig_m <= '0; dig_s <= '0;
      al_m  <= 1'b0; al_s <= 1'b0;
`ifdef SEVSEG_DP_CAPTURE_EN
      dp_m  <= 1'b0; dp_s <= 1'b0;
`endif
    end else begin
      seg_m <= seg_in; seg_s <= seg_m;
      dig_m <= dig_in; dig_s <= dig_m;
      al_m  <= al;     al_s  <= al_m;
`ifdef SEVSEG_DP_CAPTURE_EN
      dp_m  <= dp_in;  dp_s  <= dp_m;
`endif
    end
  end

  logic             one_hot;
  logic [IDX_W-1:0] hot_idx;

  assign one_hot = (dig_s != '0) && ((dig_s & (dig_s - NUM_DIGITS'(1))) == '0);

  always_comb begin
    hot_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (dig_s[i]) hot_idx = IDX_W'(i);
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             start, take;

  // A new one-hot strobe may be picked up straight from HOLD so back-to-back
  // strobes keep the same sampling latency as strobes separated by a gap.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    start    = 1'b0;
    take     = 1'b0;
    unique case (state)
      IDLE:   start = one_hot;
      SETTLE: begin
        if (one_hot && hot_idx == idx) begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt_nx == SETTLE_L) begin
            take     = 1'b1;
            state_nx = HOLD;
          end
        end else if (one_hot) begin
          start = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (!dig_s[idx]) begin
          if (one_hot) start = 1'b1;
          else         state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (start) begin
      idx_nx = hot_idx;
      cnt_nx = CNT_W'(1);
      if (SETTLE_CYCLES == 1) begin
        take     = 1'b1;
        state_nx = HOLD;
      end else begin
        state_nx = SETTLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  digit_t enc, sample;

  sevseg_glyph_encoder u_enc (
    .seg    (seg_s ^ {7{al_s}}),
    .hex_en (hex_en),
    .glyph  (enc)
  );

  always_comb begin
    sample = enc;
`ifdef SEVSEG_DP_CAPTURE_EN
    sample.dp = dp_s ^ al_s;
`endif
  end

  digit_t                cand      [NUM_DIGITS];
  digit_t                commit    [NUM_DIGITS];
  digit_t                commit_nx [NUM_DIGITS];
  logic [SCNT_W-1:0]     scnt      [NUM_DIGITS];
  logic [SCNT_W-1:0]     new_cnt;
  logic [NUM_DIGITS-1:0] mask, mask_nx;
  logic                  frame_done;

  always_comb begin
    if (sample != cand[idx_nx])       new_cnt = SCNT_W'(1);
    else if (scnt[idx_nx] == STABLE_L) new_cnt = STABLE_L;
    else                               new_cnt = scnt[idx_nx] + SCNT_W'(1);
    commit_nx = commit;
    if (take && new_cnt == STABLE_L) commit_nx[idx_nx] = sample;
    mask_nx = mask | (take ? (NUM_DIGITS'(1) << idx_nx) : '0);
    frame_done = (mask_nx == '1);
  end

  logic [4*NUM_DIGITS-1:0] data_nx;
  logic [NUM_DIGITS-1:0]   blank_nx, err_nx;
`ifdef SEVSEG_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0]   dp_nx;
`endif

  always_comb begin
    data_nx  = '0;
    blank_nx = '0;
    err_nx   = '0;
`ifdef SEVSEG_DP_CAPTURE_EN
    dp_nx    = '0;
`endif
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      data_nx[4*i +: 4] = commit_nx[i].code;
      blank_nx[i]       = commit_nx[i].blank;
      err_nx[i]         = commit_nx[i].err;
`ifdef SEVSEG_DP_CAPTURE_EN
      dp_nx[i]          = commit_nx[i].dp;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        cand[i]   <= '0;
        commit[i] <= '0;
        scnt[i]   <= '0;
      end
      mask        <= '0;
      frame_data  <= '0;
      frame_blank <= '0;
      frame_err   <= '0;
`ifdef SEVSEG_DP_CAPTURE_EN
      frame_dp    <= '0;
`endif
      frame_ovr   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      commit <= commit_nx;
      if (take) begin
        cand[idx_nx] <= sample;
        scnt[idx_nx] <= new_cnt;
      end
      mask <= frame_done ? '0 : mask_nx;
      if (frame_done && (!frame_valid || frame_ready)) begin
        frame_data  <= data_nx;
        frame_blank <= blank_nx;
        frame_err   <= err_nx;
`ifdef SEVSEG_DP_CAPTURE_EN
        frame_dp    <= dp_nx;
`endif
        frame_valid <= 1'b1;
        frame_ovr   <= 1'b0;
      end else if (frame_done) begin
        frame_ovr   <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
        frame_ovr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan_reader.sv
// Self-checking bench for sevseg_scan_reader (default build, no dp capture).
module tb_sevseg_scan_reader;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int SS = 2;

  typedef struct packed {
    logic [4*ND-1:0] data;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
    logic            ovr;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6:0]      seg_in = '0;
  logic [ND-1:0]   dig_in = '0;
  logic            al = 1'b0;
  logic            hex_en = 1'b1;
  logic [4*ND-1:0] frame_data;
  logic [ND-1:0]   frame_blank, frame_err;
  logic            frame_ovr, frame_valid;
  logic            frame_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  sevseg_scan_reader #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC), .STABLE_SCANS(SS)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_in(dig_in), .al(al), .hex_en(hex_en),
    .frame_data(frame_data), .frame_blank(frame_blank), .frame_err(frame_err),
    .frame_ovr(frame_ovr), .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  // Accepted frames, observed mid-cycle.
  frame_t got_q[$];
  always @(negedge clk)
    if (!rst && frame_valid && frame_ready)
      got_q.push_back({frame_data, frame_blank, frame_err, frame_ovr});

  // Reference model: per-digit {code,blank,err} history and expected frames.
  logic [5:0] m_cand[ND];
  int         m_cnt[ND];
  logic [5:0] m_commit[ND];
  bit         m_seen[ND];
  frame_t     exp_q[$];
  logic [6:0] scan_pat[ND];
  int         scan_len[ND];

  function automatic logic [5:0] ref_decode(input logic [6:0] p, input logic hx);
    case (p)
      7'h3F: return {4'h0, 2'b00};
      7'h06: return {4'h1, 2'b00};
      7'h5B: return {4'h2, 2'b00};
      7'h4F: return {4'h3, 2'b00};
      7'h66: return {4'h4, 2'b00};
      7'h6D: return {4'h5, 2'b00};
      7'h7D: return {4'h6, 2'b00};
      7'h07, 7'h27: return {4'h7, 2'b00};
      7'h7F: return {4'h8, 2'b00};
      7'h6F, 7'h67: return {4'h9, 2'b00};
      7'h77: return {4'hA, 2'b00};
      7'h7C: return {(hx ? 4'hB : 4'h6), 2'b00};
      7'h39: return {4'hC, 2'b00};
      7'h5E: return {4'hD, 2'b00};
      7'h79: return {4'hE, 2'b00};
      7'h71: return {4'hF, 2'b00};
      7'h00: return 6'b0000_10;
      default: return 6'b0000_01;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_cand[i] = '0; m_cnt[i] = 0; m_commit[i] = '0; m_seen[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_sample(input int d, input logic [6:0] p, input logic hx);
    logic [5:0] v;
    bit all;
    frame_t f;
    v = ref_decode(p, hx);
    if (m_cnt[d] == 0 || v != m_cand[d]) begin
      m_cand[d] = v; m_cnt[d] = 1;
    end else if (m_cnt[d] < SS) begin
      m_cnt[d]++;
    end
    if (m_cnt[d] == SS) m_commit[d] = v;
    m_seen[d] = 1;
    all = 1;
    for (int i = 0; i < ND; i++) all &= m_seen[i];
    if (all) begin
      f = '0;
      for (int i = 0; i < ND; i++) begin
        f.data[4*i +: 4] = m_commit[i][5:2];
        f.blank[i]       = m_commit[i][1];
        f.err[i]         = m_commit[i][0];
        m_seen[i]        = 0;
      end
      exp_q.push_back(f);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1 frame_ready = v;
  endtask

  task automatic run_scan(input logic hx, input logic a);
    @(negedge clk); hex_en = hx; al = a;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      dig_in = ND'(1) << d;
      seg_in = scan_pat[d] ^ {7{a}};
      repeat (scan_len[d]) @(negedge clk);
      dig_in = '0;
      repeat (2) @(negedge clk);
      if (scan_len[d] >= SC) model_sample(d, scan_pat[d], hx);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", frame_data); end
    checks++; if ({frame_blank, frame_err, frame_ovr} !== '0) begin errors++; $display("FAIL reset_flags got %b want 0", {frame_blank, frame_err, frame_ovr}); end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    scan_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    scan_len = '{4, 4, 4, 4};
    run_scan(1'b1, 1'b0);
    run_scan(1'b1, 1'b0);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL basic_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[1].data !== 16'h3210) begin errors++; $display("FAIL basic_data got %h want 3210", got_q[1].data); end
      checks++; if ({got_q[1].blank, got_q[1].err} !== '0) begin errors++; $display("FAIL basic_flags got %b want 0", {got_q[1].blank, got_q[1].err}); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_frame%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glyphs();
    logic [6:0] pats[6] = '{7'h7C, 7'h7C, 7'h67, 7'h27, 7'h00, 7'h49};
    logic       hxs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0] want[6] = '{6'b0110_00, 6'b1011_00, 6'b1001_00, 6'b0111_00, 6'b0000_10, 6'b0000_01};
    for (int t = 0; t < 6; t++) begin
      scan_pat = '{pats[t], 7'h06, 7'h5B, 7'h4F};
      scan_len = '{4, 4, 4, 4};
      run_scan(hxs[t], t[0]);
      run_scan(hxs[t], t[0]);
      checks++;
      if (got_q.size() != 2) begin
        errors++; $display("FAIL glyph%0d_count got %0d want 2", t, got_q.size());
      end else if ({got_q[1].data[3:0], got_q[1].blank[0], got_q[1].err[0]} !== want[t]) begin
        errors++; $display("FAIL glyph%0d got %b want %b", t,
                           {got_q[1].data[3:0], got_q[1].blank[0], got_q[1].err[0]}, want[t]);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glyph%0d_frame%0d got %h want %h", t, i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_short_strobe();
    scan_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    scan_len = '{4, 4, SC - 1, 4};
    run_scan(1'b1, 1'b0);
    checks++; if (got_q.size() != 0 || frame_valid !== 1'b0) begin errors++; $display("FAIL short_no_frame got %0d/%b want 0/0", got_q.size(), frame_valid); end
    scan_len = '{1, 1, SC, 1};
    run_scan(1'b1, 1'b0);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL short_complete got %0d want 1", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_frame%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    frame_t held;
    set_ready(1'b0);
    scan_pat = '{7'h66, 7'h6D, 7'h7D, 7'h07};
    scan_len = '{4, 4, 4, 4};
    run_scan(1'b1, 1'b0);
    held = exp_q[0];
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", frame_valid); end
    checks++; if ({frame_data, frame_blank, frame_err, frame_ovr} !== held) begin errors++; $display("FAIL ovr_first got %h want %h", {frame_data, frame_blank, frame_err, frame_ovr}, held); end
    run_scan(1'b1, 1'b0);
    held.ovr = 1'b1;
    checks++; if ({frame_data, frame_blank, frame_err, frame_ovr} !== held) begin errors++; $display("FAIL ovr_held got %h want %h", {frame_data, frame_blank, frame_err, frame_ovr}, held); end
    set_ready(1'b1);
    set_ready(1'b0);
    checks++; if (got_q.size() != 1 || got_q[0] !== held) begin errors++; $display("FAIL ovr_transfer got n=%0d want %h", got_q.size(), held); end
    @(negedge clk);
    checks++; if ({frame_valid, frame_ovr} !== 2'b00) begin errors++; $display("FAIL ovr_clear got %b want 00", {frame_valid, frame_ovr}); end
    set_ready(1'b1);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_alternate();
    scan_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    scan_len = '{4, 4, 4, 4};
    run_scan(1'b1, 1'b0);
    run_scan(1'b1, 1'b0);
    got_q.delete(); exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      scan_pat[1] = s[0] ? 7'h06 : 7'h5B;
      run_scan(1'b1, 1'b0);
    end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL alt_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i].data[7:4] !== 4'h1) begin errors++; $display("FAIL alt_digit1_%0d got %h want 1", i, got_q[i].data[7:4]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL alt_frame%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [6:0] pool[12] = '{7'h3F, 7'h06, 7'h7C, 7'h00, 7'h49, 7'h67, 7'h27, 7'h77, 7'h5E, 7'h71, 7'h7F, 7'h39};
    for (int s = 0; s < 24; s++) begin
      for (int d = 0; d < ND; d++) begin
        scan_pat[d] = ($urandom_range(0, 5) == 0) ? 7'($urandom) : pool[$urandom_range(0, 11)];
        scan_len[d] = $urandom_range(1, 5);
      end
      run_scan(1'($urandom), 1'($urandom));
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    set_ready(1'b0);
    scan_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    scan_len = '{4, 4, 4, 4};
    run_scan(1'b1, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", frame_valid); end
    dig_in = 4'b0001;
    seg_in = 7'h3F;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({frame_valid, frame_ovr} !== 2'b00) begin errors++; $display("FAIL rstmid_valid got %b want 00", {frame_valid, frame_ovr}); end
    checks++; if ({frame_data, frame_blank, frame_err} !== '0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", {frame_data, frame_blank, frame_err}); end
    dig_in = '0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    got_q.delete();
    set_ready(1'b1);
    run_scan(1'b1, 1'b0);
    run_scan(1'b1, 1'b0);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rstmid_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0].data !== 16'h0000) begin errors++; $display("FAIL rstmid_first got %h want 0000", got_q[0].data); end
      checks++; if (got_q[1].data !== 16'h3210) begin errors++; $display("FAIL rstmid_second got %h want 3210", got_q[1].data); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_frame%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glyphs();
    test_short_strobe();
    test_overflow();
    test_alternate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
